// File: rtl/prgm_loader.sv
// Program memory loader: erase, stream bytes in, write, then read back
// and check against the running sum and a trailing checksum byte.
module prgm_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [6:0]    len,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [AW-1:0] mem_adrs,
  output logic          mem_erase,
  output logic          mem_mode,
  output logic [7:0]    mem_data,
  input  logic [7:0]    mem_out,
  output logic          busy,
  output logic          done,
  output logic [1:0]    error,
  output logic [7:0]    sum
);

  typedef enum logic [3:0] {
    IDLE, ERASE, WAIT, PRIME, WR1, WR2,
    WR3, CHK, RD1, RD2, RD3, FIN
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [6:0]    len_q, len_d;
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    acc_q, acc_d;
  logic [7:0]    data_q, data_d;
  logic [1:0]    err_q, err_d;
  logic          done_q, done_d;
  logic          rdy_q, erase_q, mode_q, busy_q;
  logic          accept, last, len_ok;

  assign accept = in_valid & rdy_q;
  assign last   = (7'(addr_q) == len_q - 7'd1);
  assign len_ok = (len != 7'd0) && (len <= 7'(DEPTH));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    sum_d   = sum_q;
    acc_d   = acc_q;
    data_d  = data_q;
    err_d   = err_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            len_d   = len;
            sum_d   = 8'h00;
            err_d   = 2'd0;
            state_d = ERASE;
          end else begin
            err_d  = 2'd1;
            done_d = 1'b1;
          end
        end
      end
      ERASE: begin
        addr_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (accept) begin
          data_d  = in_data;
          sum_d   = sum_q + in_data;
          state_d = PRIME;
        end
      end
      PRIME: state_d = WR1;
      WR1:   state_d = WR2;
      WR2:   state_d = WR3;
      WR3: begin
        if (last) begin
          state_d = CHK;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = WAIT;
        end
      end
      CHK: begin
        if (accept) begin
          if (8'(sum_q + in_data) != 8'h00) err_d = 2'd2;
          addr_d  = '0;
          acc_d   = 8'h00;
          state_d = RD1;
        end
      end
      RD1: state_d = RD2;
      RD2: state_d = RD3;
      RD3: begin
        acc_d = acc_q + mem_out;
        if (last) begin
          state_d = FIN;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = RD1;
        end
      end
      FIN: begin
        if (acc_q != sum_q && err_q == 2'd0) err_d = 2'd3;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= 7'd0;
      sum_q   <= 8'h00;
      acc_q   <= 8'h00;
      data_q  <= 8'h00;
      err_q   <= 2'd0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
      erase_q <= 1'b0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      err_q   <= err_d;
      done_q  <= done_d;
      rdy_q   <= (state_d == WAIT) || (state_d == CHK);
      erase_q <= (state_d == ERASE);
      mode_q  <= (state_d == WR1) || (state_d == WR2) ||
                 (state_d == WR3);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign in_ready  = rdy_q;
  assign mem_adrs  = addr_q;
  assign mem_erase = erase_q;
  assign mem_mode  = mode_q;
  assign mem_data  = data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = err_q;
  assign sum       = sum_q;

endmodule

// File: tb/tb_prgm_loader.sv
// Directed bench for prgm_loader with a behavioural 64x8 memory
// and a posedge event monitor.
module tb_prgm_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] len = 7'd0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] mem_adrs;
  logic       mem_erase, mem_mode;
  logic [7:0] mem_data, mem_out;
  logic       busy, done;
  logic [1:0] error;
  logic [7:0] sum;

  prgm_loader #(.DEPTH(64), .AW(6)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_adrs(mem_adrs), .mem_erase(mem_erase),
    .mem_mode(mem_mode), .mem_data(mem_data), .mem_out(mem_out),
    .busy(busy), .done(done), .error(error), .sum(sum)
  );

  always #5 clk = ~clk;

  int nchk = 0, nfail = 0;
  int gcyc = 0, ndone = 0, tdone = 0, nerase = 0, nwr = 0;
  int nbusy = 0, nbad = 0, nboth = 0, lastwa = 0, cur_len = 64;
  logic       flip = 1'b0;
  logic [7:0] pm [64];
  logic [7:0] stim [64];

  // Memory model plus event counters, sampled on the rising edge.
  always @(posedge clk) begin
    gcyc <= gcyc + 1;
    if (done) begin
      ndone <= ndone + 1;
      tdone <= gcyc;
    end
    if (busy) nbusy <= nbusy + 1;
    if (mem_erase && mem_mode) nboth <= nboth + 1;
    if (mem_erase) begin
      nerase <= nerase + 1;
      for (int i = 0; i < 64; i++) pm[i] <= 8'h00;
    end else if (mem_mode) begin
      pm[mem_adrs] <= mem_data;
      nwr <= nwr + 1;
      lastwa <= int'(mem_adrs);
      if (int'(mem_adrs) >= cur_len) nbad <= nbad + 1;
    end
    mem_out <= pm[mem_adrs] ^ (flip ? 8'h01 : 8'h00);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int k = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) check("send_wait", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic session(input int l, input logic [7:0] ck,
                         input int stall, input bit extra,
                         input int exp_lat, input string nm);
    int t0, n0, k, lo, wr;
    cur_len = l;
    n0 = ndone;
    start = 1'b1;
    len = 7'(l);
    t0 = gcyc;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < l; i++) begin
      if (i == 1 && stall > 0) begin
        k = 0;
        while (!in_ready && k < 50) begin
          @(negedge clk);
          k++;
        end
        lo = 0;
        wr = 0;
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          if (!in_ready) lo++;
          if (mem_mode) wr++;
        end
        check({nm, "_stall_rdy_low"}, 32'(lo), 0);
        check({nm, "_stall_writes"}, 32'(wr), 0);
      end
      send(stim[i]);
      if (extra && (i == 10 || i == 40)) begin
        start = 1'b1;
        len = (i == 10) ? 7'd5 : 7'd0;
        @(negedge clk);
        start = 1'b0;
      end
    end
    send(ck);
    k = 0;
    while (ndone == n0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (exp_lat > 0) check({nm, "_latency"}, 32'(tdone - t0), 32'(exp_lat));
    repeat (3) @(negedge clk);
    check({nm, "_done_pulses"}, 32'(ndone - n0), 1);
    check({nm, "_busy_after"}, 32'(busy), 0);
  endtask

  task automatic illegal(input logic [6:0] l, input string nm);
    int t0, n0, e0, b0, k;
    n0 = ndone;
    e0 = nerase;
    b0 = nbusy;
    start = 1'b1;
    len = l;
    t0 = gcyc;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (ndone == n0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check({nm, "_latency"}, 32'(tdone - t0), 1);
    check({nm, "_error"}, 32'(error), 1);
    check({nm, "_done_pulses"}, 32'(ndone - n0), 1);
    check({nm, "_erase"}, 32'(nerase - e0), 0);
    check({nm, "_busy"}, 32'(nbusy - b0), 0);
  endtask

  initial begin
    int k, e0, w0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_adrs", 32'(mem_adrs), 0);
    check("rst_erase", 32'(mem_erase), 0);
    check("rst_mode", 32'(mem_mode), 0);
    check("rst_data", 32'(mem_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_sum", 32'(sum), 0);
    rst = 1'b0;
    @(negedge clk);

    // reset in the middle of a write burst
    cur_len = 3;
    start = 1'b1;
    len = 7'd3;
    @(negedge clk);
    start = 1'b0;
    send(8'hAA);
    k = 0;
    while (!mem_mode && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_mode", 32'(mem_mode), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_rdy", 32'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // nominal load
    stim[0] = 8'h11; stim[1] = 8'h22; stim[2] = 8'h33;
    e0 = nerase;
    w0 = nwr;
    session(3, 8'h9A, 0, 1'b0, 28, "nom");
    check("nom_sum", 32'(sum), 32'h66);
    check("nom_error", 32'(error), 0);
    check("nom_erase", 32'(nerase - e0), 1);
    check("nom_writes", 32'(nwr - w0), 9);
    check("nom_m0", 32'(pm[0]), 32'h11);
    check("nom_m1", 32'(pm[1]), 32'h22);
    check("nom_m2", 32'(pm[2]), 32'h33);

    // bad checksum still runs verify
    stim[0] = 8'h01; stim[1] = 8'h02;
    session(2, 8'h00, 0, 1'b0, 20, "badck");
    check("badck_error", 32'(error), 2);
    check("badck_sum", 32'(sum), 32'h03);

    // stall between bytes
    stim[0] = 8'h5A; stim[1] = 8'hA5;
    session(2, 8'h01, 10, 1'b0, 0, "stall");
    check("stall_error", 32'(error), 0);
    check("stall_m0", 32'(pm[0]), 32'h5A);
    check("stall_m1", 32'(pm[1]), 32'hA5);

    illegal(7'd0, "len0");
    illegal(7'd65, "len65");

    // corrupted readback
    flip = 1'b1;
    stim[0] = 8'h05;
    session(1, 8'hFB, 0, 1'b0, 12, "rdbk");
    check("rdbk_error", 32'(error), 3);
    flip = 1'b0;

    // full depth with ignored starts
    for (int i = 0; i < 64; i++) stim[i] = 8'(i);
    session(64, 8'h20, 0, 1'b1, 516, "full");
    check("full_sum", 32'(sum), 32'hE0);
    check("full_error", 32'(error), 0);
    check("full_lastwa", 32'(lastwa), 63);
    check("full_m63", 32'(pm[63]), 32'h3F);
    check("full_m32", 32'(pm[32]), 32'h20);
    check("adrs_range", 32'(nbad), 0);
    check("erase_mode_both", 32'(nboth), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
